bus_demux4: RTL and testbench

- Single-initiator to four-target data-bus demultiplexer; the distribution-side counterpart of the core's 4:1 result selection.
- Sits between the single-cycle core's data-memory port and four targets: data RAM, UART, timer, GPIO.
- Decodes the address region, forwards one request at a time to the matching target, and routes that target's response back.
- Unmapped addresses and unresponsive targets return an error response.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_demux4_if.sv | 43 ++++
 rtl/bus_addr_decode.sv | 34 +++
 rtl/bus_demux4.sv | 133 +++++++++++++
 tb/tb_bus_demux4.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types for the four-target data-bus demultiplexer.
package bus_pkg;

    localparam int N_TARGETS  = 4;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Response returned to the initiator; rdata is zero whenever err is set.
    typedef struct packed {
        logic [BUS_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/bus_demux4_if.sv
// Initiator-side and target-side bus signals of the demultiplexer.
interface bus_demux4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import bus_pkg::*;

    logic                          m_req_valid;
    logic                          m_req_ready;
    logic [ADDR_W-1:0]             m_addr;
    logic                          m_we;
    logic [DATA_W-1:0]             m_wdata;
    logic [DATA_W/8-1:0]           m_be;
    logic                          m_rsp_valid;
    logic                          m_rsp_ready;
    logic [DATA_W-1:0]             m_rsp_rdata;
    logic                          m_rsp_err;

    logic [N_TARGETS-1:0]          t_req_valid;
    logic [N_TARGETS-1:0]          t_req_ready;
    logic [ADDR_W-1:0]             t_addr;
    logic                          t_we;
    logic [DATA_W-1:0]             t_wdata;
    logic [DATA_W/8-1:0]           t_be;
    logic [N_TARGETS-1:0]          t_rsp_valid;
    logic [N_TARGETS*DATA_W-1:0]   t_rsp_rdata;

    // The demux itself: slave to the initiator, driver of the target side.
    modport slave (
        input  m_req_valid, m_addr, m_we, m_wdata, m_be, m_rsp_ready,
        input  t_req_ready, t_rsp_valid, t_rsp_rdata,
        output m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err,
        output t_req_valid, t_addr, t_we, t_wdata, t_be
    );

    modport master (
        output m_req_valid, m_addr, m_we, m_wdata, m_be, m_rsp_ready,
        output t_req_ready, t_rsp_valid, t_rsp_rdata,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err,
        input  t_req_valid, t_addr, t_we, t_wdata, t_be
    );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address-region decode; on overlapping regions the lowest
// target index wins.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] REGION_MASK = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] BASE0       = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] BASE1       = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] BASE2       = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] BASE3       = 32'h4000_0000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        idx,
    output logic              hit
);

    logic [N_TARGETS-1:0] match;

    assign match[0] = ((addr & REGION_MASK) == BASE0);
    assign match[1] = ((addr & REGION_MASK) == BASE1);
    assign match[2] = ((addr & REGION_MASK) == BASE2);
    assign match[3] = ((addr & REGION_MASK) == BASE3);

    // Scanning downward leaves the lowest matching index in idx.
    always_comb begin
        hit = |match;
        idx = 2'd0;
        for (int n = N_TARGETS - 1; n >= 0; n--) begin
            if (match[n]) idx = 2'(n);
        end
    end

endmodule

// File: rtl/bus_demux4.sv
// Single-initiator to four-target bus demultiplexer with decode-error and
// response-timeout handling; one transaction outstanding at a time.
module bus_demux4
    import bus_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] REGION_MASK = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] BASE0       = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] BASE1       = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] BASE2       = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] BASE3       = 32'h4000_0000,
    parameter int                TIMEOUT     = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_demux4_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state;
    state_t               state_nx;
    logic [1:0]           sel;
    logic [ADDR_W-1:0]    addr_q;
    logic                 we_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W/8-1:0]  be_q;
    rsp_t                 rsp_q;
    logic [CNT_W-1:0]     cnt;

    logic [1:0]           dec_idx;
    logic                 dec_hit;
    logic                 sel_ready;
    logic                 sel_rsp;
    logic [DATA_W-1:0]    sel_rdata;
    logic                 timeout_hit;

    logic                 req_ready_c;
    logic                 rsp_valid_c;
    logic [N_TARGETS-1:0] t_req_valid_c;

    bus_addr_decode #(
        .ADDR_W      (ADDR_W),
        .REGION_MASK (REGION_MASK),
        .BASE0       (BASE0),
        .BASE1       (BASE1),
        .BASE2       (BASE2),
        .BASE3       (BASE3)
    ) u_decode (
        .addr (bus.m_addr),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    assign sel_ready   = bus.t_req_ready[sel];
    assign sel_rsp     = bus.t_rsp_valid[sel];
    assign sel_rdata   = bus.t_rsp_rdata[sel*DATA_W +: DATA_W];
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.m_req_valid) state_nx = dec_hit ? ISSUE : RESP;
            ISSUE: if (sel_ready)       state_nx = sel_rsp ? RESP : WAIT;
            WAIT:  if (sel_rsp || timeout_hit) state_nx = RESP;
            RESP:  if (bus.m_rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The reset term keeps the initiator from handing over a request that
    // the asynchronously cleared state would otherwise appear to accept.
    always_comb begin
        req_ready_c   = (state == IDLE) && !rst;
        rsp_valid_c   = (state == RESP);
        t_req_valid_c = '0;
        if (state == ISSUE) t_req_valid_c[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rsp_q   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m_req_valid) begin
                        sel     <= dec_idx;
                        addr_q  <= bus.m_addr;
                        we_q    <= bus.m_we;
                        wdata_q <= bus.m_wdata;
                        be_q    <= bus.m_be;
                        if (!dec_hit) rsp_q <= '{rdata: '0, err: 1'b1};
                    end
                end
                ISSUE: begin
                    if (sel_ready) begin
                        if (sel_rsp) rsp_q <= '{rdata: sel_rdata, err: 1'b0};
                        else         cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (sel_rsp)          rsp_q <= '{rdata: sel_rdata, err: 1'b0};
                    else if (timeout_hit) rsp_q <= '{rdata: '0, err: 1'b1};
                    else                  cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.m_req_ready = req_ready_c;
    assign bus.m_rsp_valid = rsp_valid_c;
    assign bus.m_rsp_rdata = rsp_q.rdata;
    assign bus.m_rsp_err   = rsp_q.err;
    assign bus.t_req_valid = t_req_valid_c;
    assign bus.t_addr      = addr_q;
    assign bus.t_we        = we_q;
    assign bus.t_wdata     = wdata_q;
    assign bus.t_be        = be_q;

endmodule

// File: tb/tb_bus_demux4.sv
// Directed-vector bench for bus_demux4: fast, slow, unmapped and silent
// targets, response back-pressure, reset mid-transaction, stray responses.
module tb_bus_demux4;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vectors     = 0;
    int   n_miscompares = 0;
    int   wait_cycles;
    int   stray_rsp;

    always #5 clk = ~clk;

    bus_demux4_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    bus_demux4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                 input logic [31:0] wdata, input logic [3:0] be);
        bif.m_req_valid = 1'b1;
        bif.m_addr      = addr;
        bif.m_we        = we;
        bif.m_wdata     = wdata;
        bif.m_be        = be;
    endtask

    task automatic setTargetData(input int n, input logic [31:0] data);
        bif.t_rsp_rdata[n*32 +: 32] = data;
    endtask

    task automatic rspHandshake();
        bif.m_rsp_ready = 1'b1;
        tick();
        bif.m_rsp_ready = 1'b0;
    endtask

    // Hard stop in case the DUT wedges somewhere a bounded loop does not cover.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bif.m_req_valid = 1'b0;
        bif.m_addr      = '0;
        bif.m_we        = 1'b0;
        bif.m_wdata     = '0;
        bif.m_be        = '0;
        bif.m_rsp_ready = 1'b0;
        bif.t_req_ready = '0;
        bif.t_rsp_valid = '0;
        bif.t_rsp_rdata = '0;

        #12;
        checkOutput("rst_req_ready",   bif.m_req_ready, 0);
        checkOutput("rst_rsp_valid",   bif.m_rsp_valid, 0);
        checkOutput("rst_t_req_valid", bif.t_req_valid, 0);
        checkOutput("rst_rdata",       bif.m_rsp_rdata, 0);
        checkOutput("rst_err",         bif.m_rsp_err,   0);
        checkOutput("rst_t_addr",      bif.t_addr,      0);
        tick();
        rst = 1'b0;
        tick();

        // Fast read from target 1 with a stray response from target 2.
        applyStimulus(32'h1000_0010, 1'b0, 32'h0, 4'hF);
        checkOutput("t1_req_ready", bif.m_req_ready, 1);
        tick();
        bif.m_req_valid = 1'b0;
        checkOutput("t1_t_req_valid", bif.t_req_valid, 4'b0010);
        checkOutput("t1_t_addr",      bif.t_addr,      32'h1000_0010);
        checkOutput("t1_t_we",        bif.t_we,        0);
        bif.t_req_ready = 4'b0010;
        bif.t_rsp_valid = 4'b0110;
        setTargetData(1, 32'hCAFE_F00D);
        setTargetData(2, 32'hDEAD_BEEF);
        tick();
        bif.t_req_ready = '0;
        bif.t_rsp_valid = '0;
        checkOutput("t1_rsp_valid",   bif.m_rsp_valid, 1);
        checkOutput("t1_rdata",       bif.m_rsp_rdata, 32'hCAFE_F00D);
        checkOutput("t1_err",         bif.m_rsp_err,   0);
        checkOutput("t1_resp_ready",  bif.m_req_ready, 0);
        checkOutput("t1_resp_tvalid", bif.t_req_valid, 0);
        rspHandshake();
        checkOutput("t1_idle_rsp_valid", bif.m_rsp_valid, 0);
        checkOutput("t1_idle_req_ready", bif.m_req_ready, 1);

        // Write to target 3, which stalls ready for 3 cycles then answers later.
        applyStimulus(32'h4000_0004, 1'b1, 32'h1234_5678, 4'b0011);
        tick();
        bif.m_req_valid = 1'b0;
        bif.m_addr      = 32'hFFFF_FFFF;
        bif.m_wdata     = 32'hFFFF_FFFF;
        bif.m_be        = 4'hF;
        bif.m_we        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_t_req_valid", bif.t_req_valid, 4'b1000);
            checkOutput("t2_t_addr",      bif.t_addr,      32'h4000_0004);
            checkOutput("t2_t_wdata",     bif.t_wdata,     32'h1234_5678);
            checkOutput("t2_t_be",        bif.t_be,        4'b0011);
            checkOutput("t2_t_we",        bif.t_we,        1);
            tick();
        end
        bif.t_req_ready = 4'b1000;
        checkOutput("t2_accept_tvalid", bif.t_req_valid, 4'b1000);
        tick();
        bif.t_req_ready = '0;
        checkOutput("t2_wait_tvalid", bif.t_req_valid, 0);
        checkOutput("t2_wait_t_addr", bif.t_addr,      32'h4000_0004);
        checkOutput("t2_wait_rsp",    bif.m_rsp_valid, 0);
        tick();
        setTargetData(3, 32'h0BAD_0003);
        bif.t_rsp_valid = 4'b1000;
        tick();
        bif.t_rsp_valid = '0;
        checkOutput("t2_rsp_valid", bif.m_rsp_valid, 1);
        checkOutput("t2_rdata",     bif.m_rsp_rdata, 32'h0BAD_0003);
        checkOutput("t2_err",       bif.m_rsp_err,   0);
        rspHandshake();

        // Unmapped address: error one cycle after acceptance, no target request.
        applyStimulus(32'h8000_0000, 1'b0, 32'h0, 4'hF);
        checkOutput("t3_req_ready", bif.m_req_ready, 1);
        tick();
        bif.m_req_valid = 1'b0;
        checkOutput("t3_t_req_valid", bif.t_req_valid, 0);
        checkOutput("t3_rsp_valid",   bif.m_rsp_valid, 1);
        checkOutput("t3_rdata",       bif.m_rsp_rdata, 0);
        checkOutput("t3_err",         bif.m_rsp_err,   1);
        rspHandshake();

        // Target 0 accepts but stays silent; a stray target-2 response must not end the wait.
        setTargetData(0, 32'h5555_5555);
        applyStimulus(32'h0000_0000, 1'b0, 32'h0, 4'hF);
        tick();
        bif.m_req_valid = 1'b0;
        checkOutput("t4_t_req_valid", bif.t_req_valid, 4'b0001);
        bif.t_req_ready = 4'b0001;
        tick();
        bif.t_req_ready = '0;
        bif.t_rsp_valid = 4'b0100;
        wait_cycles = 0;
        while (!bif.m_rsp_valid && wait_cycles < 40) begin
            tick();
            wait_cycles++;
        end
        bif.t_rsp_valid = '0;
        checkOutput("t4_wait_cycles", wait_cycles,     16);
        checkOutput("t4_rsp_valid",   bif.m_rsp_valid, 1);
        checkOutput("t4_err",         bif.m_rsp_err,   1);
        checkOutput("t4_rdata",       bif.m_rsp_rdata, 0);

        // Back-pressure in RESP while a new request is already waiting.
        applyStimulus(32'h1000_0000, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5_hold_rsp_valid", bif.m_rsp_valid, 1);
            checkOutput("t5_hold_err",       bif.m_rsp_err,   1);
            checkOutput("t5_hold_req_ready", bif.m_req_ready, 0);
            tick();
        end
        checkOutput("t5_not_issued", bif.t_req_valid, 0);
        rspHandshake();
        checkOutput("t5_idle_rsp_valid", bif.m_rsp_valid, 0);
        checkOutput("t5_idle_req_ready", bif.m_req_ready, 1);
        tick();
        bif.m_req_valid = 1'b0;
        checkOutput("t5_t_req_valid", bif.t_req_valid, 4'b0010);
        checkOutput("t5_t_addr",      bif.t_addr,      32'h1000_0000);

        // Reset while target 1 is in WAIT; the pending error flag must clear too.
        bif.t_req_ready = 4'b0010;
        tick();
        bif.t_req_ready = '0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_t_req_valid", bif.t_req_valid, 0);
        checkOutput("t6_rst_rsp_valid",   bif.m_rsp_valid, 0);
        checkOutput("t6_rst_req_ready",   bif.m_req_ready, 0);
        checkOutput("t6_rst_t_addr",      bif.t_addr,      0);
        checkOutput("t6_rst_err",         bif.m_rsp_err,   0);
        tick();
        tick();
        rst = 1'b0;
        setTargetData(1, 32'h0000_0077);
        bif.t_rsp_valid = 4'b0010;
        stray_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bif.m_rsp_valid) stray_rsp++;
        end
        bif.t_rsp_valid = '0;
        checkOutput("t6_no_rsp_after_rst", stray_rsp, 0);

        // First request after reset: fast read from target 2.
        applyStimulus(32'h2000_0008, 1'b0, 32'h0, 4'hF);
        checkOutput("t7_req_ready", bif.m_req_ready, 1);
        tick();
        bif.m_req_valid = 1'b0;
        checkOutput("t7_t_req_valid", bif.t_req_valid, 4'b0100);
        setTargetData(2, 32'h2222_3333);
        bif.t_req_ready = 4'b0100;
        bif.t_rsp_valid = 4'b0100;
        tick();
        bif.t_req_ready = '0;
        bif.t_rsp_valid = '0;
        checkOutput("t7_rsp_valid", bif.m_rsp_valid, 1);
        checkOutput("t7_rdata",     bif.m_rsp_rdata, 32'h2222_3333);
        checkOutput("t7_err",       bif.m_rsp_err,   0);
        rspHandshake();
        checkOutput("t7_idle_req_ready", bif.m_req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
